// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the alu_seq issue/write-back block.
// The optional flag outputs are enabled by defining ALU_SEQ_FLAGS_EN.
package alu_seq_pkg;

  localparam int REG_W = 8;
  localparam int IDX_W = 3;
  localparam int NREG  = 8;

  localparam logic [3:0] CTR_ADD = 4'b0000;
  localparam logic [3:0] CTR_SUB = 4'b0001;
  localparam logic [3:0] CTR_AND = 4'b1000;
  localparam logic [3:0] CTR_OR  = 4'b1001;
  localparam logic [3:0] CTR_XOR = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: instruction handshake, ALU bus, write-back and debug signals of alu_seq.
// The master side is the upstream controller plus the external alu; the slave side is alu_seq.
// zero_flag/neg_flag exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_ldi;
  logic [3:0]       in_ctr;
  logic [IDX_W-1:0] in_rd;
  logic [IDX_W-1:0] in_rs1;
  logic [IDX_W-1:0] in_rs2;
  logic [REG_W-1:0] in_imm;
  logic [REG_W-1:0] alu_a;
  logic [REG_W-1:0] alu_b;
  logic [3:0]       alu_ctr;
  logic [REG_W-1:0] alu_o;
  logic             done;
  logic [REG_W-1:0] wb_data;
  logic [IDX_W-1:0] dbg_sel;
  logic [REG_W-1:0] dbg_data;
`ifdef ALU_SEQ_FLAGS_EN
  logic             zero_flag;
  logic             neg_flag;
`endif

  modport master (
    output in_valid, in_ldi, in_ctr, in_rd, in_rs1, in_rs2, in_imm, alu_o, dbg_sel,
    input  in_ready, alu_a, alu_b, alu_ctr, done, wb_data, dbg_data
`ifdef ALU_SEQ_FLAGS_EN
    , zero_flag, neg_flag
`endif
  );

  modport slave (
    input  in_valid, in_ldi, in_ctr, in_rd, in_rs1, in_rs2, in_imm, alu_o, dbg_sel,
    output in_ready, alu_a, alu_b, alu_ctr, done, wb_data, dbg_data
`ifdef ALU_SEQ_FLAGS_EN
    , zero_flag, neg_flag
`endif
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 8x8 register array, one synchronous write port, two operand
// read ports and one debug read port, all reads combinational.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic             ck,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [REG_W-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr1_i,
  input  logic [IDX_W-1:0] raddr2_i,
  input  logic [IDX_W-1:0] dbgAddr_i,
  output logic [REG_W-1:0] rdata1_o,
  output logic [REG_W-1:0] rdata2_o,
  output logic [REG_W-1:0] dbgData_o
);

  logic [REG_W-1:0] regs_q [NREG];

  // Clear every register on reset, otherwise write one entry when enabled.
  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o  = regs_q[raddr1_i];
  assign rdata2_o  = regs_q[raddr2_i];
  assign dbgData_o = regs_q[dbgAddr_i];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: issue/write-back stage for the external 8-bit alu.
// Accepts ldi or ALU instructions, drives alu A/B/CTR from registers, waits
// ALU_LAT edges and writes alu O back. Define ALU_SEQ_FLAGS_EN for zero/neg flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input logic     ck,
  input logic     rst,
  alu_seq_if.slave bus
);

  // Last latency count spent in EXEC before moving on to WB.
  localparam logic [1:0] LAT_LAST = 2'((ALU_LAT == 0) ? 0 : ALU_LAT - 1);

  state_t           state_q, state_d;
  logic [1:0]       latCnt_q, latCnt_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [REG_W-1:0] aluA_q, aluA_d;
  logic [REG_W-1:0] aluB_q, aluB_d;
  logic [3:0]       aluCtr_q, aluCtr_d;
  logic [REG_W-1:0] wbData_q, wbData_d;
  logic             done_q, done_d;

  logic             regWe;
  logic [IDX_W-1:0] regWaddr;
  logic [REG_W-1:0] regWdata;
  logic [REG_W-1:0] rdata1, rdata2;

  alu_seq_regfile u_regfile (
    .ck        (ck),
    .rst       (rst),
    .we_i      (regWe),
    .waddr_i   (regWaddr),
    .wdata_i   (regWdata),
    .raddr1_i  (bus.in_rs1),
    .raddr2_i  (bus.in_rs2),
    .dbgAddr_i (bus.dbg_sel),
    .rdata1_o  (rdata1),
    .rdata2_o  (rdata2),
    .dbgData_o (bus.dbg_data)
  );

  // Next state, operand capture and the single register write port selection.
  always_comb begin
    state_d  = state_q;
    latCnt_d = latCnt_q;
    rd_d     = rd_q;
    aluA_d   = aluA_q;
    aluB_d   = aluB_q;
    aluCtr_d = aluCtr_q;
    wbData_d = wbData_q;
    done_d   = 1'b0;
    regWe    = 1'b0;
    regWaddr = rd_q;
    regWdata = bus.alu_o;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_ldi) begin
            regWe    = 1'b1;
            regWaddr = bus.in_rd;
            regWdata = bus.in_imm;
            wbData_d = bus.in_imm;
            done_d   = 1'b1;
          end else begin
            aluA_d   = rdata1;
            aluB_d   = rdata2;
            aluCtr_d = bus.in_ctr;
            rd_d     = bus.in_rd;
            latCnt_d = '0;
            state_d  = (ALU_LAT == 0) ? WB : EXEC;
          end
        end
      end
      EXEC: begin
        if (latCnt_q == LAT_LAST) begin
          state_d = WB;
        end else begin
          latCnt_d = latCnt_q + 2'd1;
        end
      end
      WB: begin
        regWe    = 1'b1;
        wbData_d = bus.alu_o;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over any simultaneous accept.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q  <= IDLE;
      latCnt_q <= '0;
      rd_q     <= '0;
      aluA_q   <= '0;
      aluB_q   <= '0;
      aluCtr_q <= '0;
      wbData_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      latCnt_q <= latCnt_d;
      rd_q     <= rd_d;
      aluA_q   <= aluA_d;
      aluB_q   <= aluB_d;
      aluCtr_q <= aluCtr_d;
      wbData_q <= wbData_d;
      done_q   <= done_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic zeroFlag_q, negFlag_q;

  // Flags follow every register write, ldi included.
  always_ff @(posedge ck) begin
    if (rst) begin
      zeroFlag_q <= 1'b0;
      negFlag_q  <= 1'b0;
    end else if (regWe) begin
      zeroFlag_q <= (regWdata == '0);
      negFlag_q  <= regWdata[REG_W-1];
    end
  end

  assign bus.zero_flag = zeroFlag_q;
  assign bus.neg_flag  = negFlag_q;
`endif

  assign bus.in_ready = (state_q == IDLE);
  assign bus.alu_a    = aluA_q;
  assign bus.alu_b    = aluB_q;
  assign bus.alu_ctr  = aluCtr_q;
  assign bus.wb_data  = wbData_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: testbench for alu_seq with an external alu model of latency ALU_LAT
// and a register-array reference model. Flag checks compile in with ALU_SEQ_FLAGS_EN.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int ALU_LAT  = 1;
  localparam int PIPE_IDX = (ALU_LAT == 0) ? 0 : ALU_LAT - 1;

  logic ck;
  logic rst;
  alu_seq_if bus ();

  int errors = 0;
  int checks = 0;
  int refRegs [8];

  alu_seq #(.ALU_LAT(ALU_LAT)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // The external alu as a bit-level 8-bit unit.
  function automatic logic [7:0] envAlu(logic [3:0] c, logic [7:0] a, logic [7:0] b);
    case (c)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      default: return a;
    endcase
  endfunction

  logic [7:0] aluPipe [4];

  // alu pipeline: samples A/B/CTR each edge, result valid ALU_LAT edges later.
  always @(posedge ck) begin
    aluPipe[0] <= envAlu(bus.alu_ctr, bus.alu_a, bus.alu_b);
    for (int i = 1; i < 4; i++) aluPipe[i] <= aluPipe[i-1];
  end

  assign bus.alu_o = (ALU_LAT == 0) ? envAlu(bus.alu_ctr, bus.alu_a, bus.alu_b) : aluPipe[PIPE_IDX];

  // Expected result of an operation from integer arithmetic mod 256.
  function automatic int refResult(int ctr, int a, int b);
    case (ctr)
      0:  return (a + b) % 256;
      1:  return (a - b + 256) % 256;
      8:  return a & b;
      9:  return a | b;
      10: return a ^ b;
      default: return a;
    endcase
  endfunction

  task automatic applyReset();
    rst = 1'b1;
    @(posedge ck);
    @(posedge ck);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) refRegs[i] = 0;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge ck);
      #1;
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL waitReady in_ready=%b required 1 within 20 cycles", bus.in_ready);
    end
  endtask

  task automatic readDbg(input int sel, output logic [7:0] val);
    bus.dbg_sel = 3'(sel);
    #1;
    val = bus.dbg_data;
  endtask

  task automatic doLdi(input int rd, input int imm, output logic obsDone);
    waitReady();
    bus.in_valid = 1'b1;
    bus.in_ldi   = 1'b1;
    bus.in_rd    = 3'(rd);
    bus.in_imm   = 8'(imm);
    @(posedge ck);
    #1;
    bus.in_valid = 1'b0;
    obsDone = bus.done;
  endtask

  task automatic doAlu(input logic [3:0] ctr, input int rd, input int rs1, input int rs2,
                       output logic [7:0] obsA, output logic [7:0] obsB,
                       output logic [3:0] obsCtr, output int lat, output int busy);
    waitReady();
    bus.in_valid = 1'b1;
    bus.in_ldi   = 1'b0;
    bus.in_ctr   = ctr;
    bus.in_rd    = 3'(rd);
    bus.in_rs1   = 3'(rs1);
    bus.in_rs2   = 3'(rs2);
    @(posedge ck);
    #1;
    bus.in_valid = 1'b0;
    obsA   = bus.alu_a;
    obsB   = bus.alu_b;
    obsCtr = bus.alu_ctr;
    lat  = -1;
    busy = 0;
    for (int k = 1; k <= 10; k++) begin
      if (bus.in_ready === 1'b0) busy++;
      @(posedge ck);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    applyReset();
    checks += 6;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.in_ready); end
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.alu_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_alu_a got=%h exp=00", bus.alu_a); end
    if (bus.alu_b !== 8'h00) begin errors++; $display("[TB] FAIL reset_alu_b got=%h exp=00", bus.alu_b); end
    if (bus.alu_ctr !== 4'h0) begin errors++; $display("[TB] FAIL reset_alu_ctr got=%h exp=0", bus.alu_ctr); end
    if (bus.wb_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wb_data got=%h exp=00", bus.wb_data); end
`ifdef ALU_SEQ_FLAGS_EN
    checks += 2;
    if (bus.zero_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero_flag got=%b exp=0", bus.zero_flag); end
    if (bus.neg_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_neg_flag got=%b exp=0", bus.neg_flag); end
`endif
    for (int i = 0; i < 8; i++) begin
      readDbg(i, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg%0d got=%h exp=00", i, v); end
    end
  endtask

  task automatic test_ldi_back_to_back();
    logic [7:0] v;
    bus.in_valid = 1'b1;
    bus.in_ldi   = 1'b1;
    bus.in_rd    = 3'd1;
    bus.in_imm   = 8'd11;
    @(posedge ck);
    #1;
    refRegs[1] = 11;
    checks += 2;
    if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL ldi1_done got=%b exp=1", bus.done); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ldi1_ready got=%b exp=1", bus.in_ready); end
    bus.in_rd  = 3'd2;
    bus.in_imm = 8'd2;
    @(posedge ck);
    #1;
    refRegs[2] = 2;
    bus.in_valid = 1'b0;
    checks += 3;
    if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL ldi2_done got=%b exp=1", bus.done); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ldi2_ready got=%b exp=1", bus.in_ready); end
    if (bus.wb_data !== 8'd2) begin errors++; $display("[TB] FAIL ldi2_wb_data got=%0d exp=2", bus.wb_data); end
    @(posedge ck);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL ldi_done_drop got=%b exp=0", bus.done); end
    for (int i = 1; i <= 2; i++) begin
      readDbg(i, v);
      checks++;
      if (v !== 8'(refRegs[i])) begin errors++; $display("[TB] FAIL ldi_reg%0d got=%0d exp=%0d", i, v, refRegs[i]); end
    end
  endtask

  task automatic test_alu_add();
    logic [7:0] a, b, v;
    logic [3:0] c;
    int lat, busy, exp;
    exp = refResult(0, refRegs[1], refRegs[2]);
    doAlu(CTR_ADD, 3, 1, 2, a, b, c, lat, busy);
    refRegs[3] = exp;
    checks += 6;
    if (a !== 8'd11) begin errors++; $display("[TB] FAIL add_alu_a got=%0d exp=11", a); end
    if (b !== 8'd2) begin errors++; $display("[TB] FAIL add_alu_b got=%0d exp=2", b); end
    if (c !== CTR_ADD) begin errors++; $display("[TB] FAIL add_alu_ctr got=%h exp=%h", c, CTR_ADD); end
    if (busy != ALU_LAT + 1) begin errors++; $display("[TB] FAIL add_busy got=%0d exp=%0d", busy, ALU_LAT + 1); end
    if (lat != ALU_LAT + 1) begin errors++; $display("[TB] FAIL add_done_latency got=%0d exp=%0d", lat, ALU_LAT + 1); end
    if (bus.wb_data !== 8'd13) begin errors++; $display("[TB] FAIL add_wb_data got=%0d exp=13", bus.wb_data); end
    readDbg(3, v);
    checks++;
    if (v !== 8'd13) begin errors++; $display("[TB] FAIL add_reg3 got=%0d exp=13", v); end
    @(posedge ck);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL add_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_sub_wrap();
    logic [7:0] a, b, v;
    logic [3:0] c;
    int lat, busy, exp;
    exp = refResult(1, refRegs[1], refRegs[2]);
    doAlu(CTR_SUB, 1, 1, 2, a, b, c, lat, busy);
    refRegs[1] = exp;
    readDbg(1, v);
    checks += 2;
    if (v !== 8'd9) begin errors++; $display("[TB] FAIL sub_rd_eq_rs1 got=%0d exp=9", v); end
    if (lat != ALU_LAT + 1) begin errors++; $display("[TB] FAIL sub_latency got=%0d exp=%0d", lat, ALU_LAT + 1); end
    exp = refResult(1, refRegs[2], refRegs[1]);
    doAlu(CTR_SUB, 4, 2, 1, a, b, c, lat, busy);
    refRegs[4] = exp;
    readDbg(4, v);
    checks += 2;
    if (v !== 8'd249) begin errors++; $display("[TB] FAIL sub_wrap got=%0d exp=249", v); end
    if (bus.wb_data !== 8'd249) begin errors++; $display("[TB] FAIL sub_wrap_wb got=%0d exp=249", bus.wb_data); end
`ifdef ALU_SEQ_FLAGS_EN
    checks += 2;
    if (bus.neg_flag !== 1'b1) begin errors++; $display("[TB] FAIL sub_neg_flag got=%b exp=1", bus.neg_flag); end
    if (bus.zero_flag !== 1'b0) begin errors++; $display("[TB] FAIL sub_zero_flag got=%b exp=0", bus.zero_flag); end
`endif
  endtask

  task automatic test_logic_ops();
    logic [7:0] a, b, v;
    logic [3:0] c;
    logic d;
    int lat, busy, exp;
    doLdi(6, 8'h96, d);
    refRegs[6] = 8'h96;
    doLdi(7, 8'h0F, d);
    refRegs[7] = 8'h0F;
    checks += 4;
    if (d !== 1'b1) begin errors++; $display("[TB] FAIL ldi_done got=%b exp=1", d); end
    if (bus.alu_a !== 8'd2) begin errors++; $display("[TB] FAIL ldi_keeps_alu_a got=%0d exp=2", bus.alu_a); end
    if (bus.alu_b !== 8'd9) begin errors++; $display("[TB] FAIL ldi_keeps_alu_b got=%0d exp=9", bus.alu_b); end
    if (bus.alu_ctr !== CTR_SUB) begin errors++; $display("[TB] FAIL ldi_keeps_alu_ctr got=%h exp=%h", bus.alu_ctr, CTR_SUB); end
    exp = refResult(8, refRegs[6], refRegs[7]);
    doAlu(CTR_AND, 5, 6, 7, a, b, c, lat, busy);
    refRegs[5] = exp;
    readDbg(5, v);
    checks++;
    if (v !== 8'h06) begin errors++; $display("[TB] FAIL and_r5 got=%h exp=06", v); end
    exp = refResult(10, refRegs[5], refRegs[5]);
    doAlu(CTR_XOR, 5, 5, 5, a, b, c, lat, busy);
    refRegs[5] = exp;
    readDbg(5, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("[TB] FAIL xor_r5 got=%h exp=00", v); end
`ifdef ALU_SEQ_FLAGS_EN
    checks += 2;
    if (bus.zero_flag !== 1'b1) begin errors++; $display("[TB] FAIL xor_zero_flag got=%b exp=1", bus.zero_flag); end
    if (bus.neg_flag !== 1'b0) begin errors++; $display("[TB] FAIL xor_neg_flag got=%b exp=0", bus.neg_flag); end
`endif
    exp = refResult(9, refRegs[6], refRegs[7]);
    doAlu(CTR_OR, 0, 6, 7, a, b, c, lat, busy);
    refRegs[0] = exp;
    readDbg(0, v);
    checks++;
    if (v !== 8'h9F) begin errors++; $display("[TB] FAIL or_r0 got=%h exp=9f", v); end
  endtask

  // An ldi held valid while an ALU op is in flight waits for the write-back.
  task automatic test_back_to_back();
    logic [7:0] v;
    int lat, exp;
    exp = refResult(0, refRegs[6], refRegs[7]);
    waitReady();
    bus.in_valid = 1'b1;
    bus.in_ldi   = 1'b0;
    bus.in_ctr   = CTR_ADD;
    bus.in_rd    = 3'd2;
    bus.in_rs1   = 3'd6;
    bus.in_rs2   = 3'd7;
    @(posedge ck);
    #1;
    bus.in_ldi = 1'b1;
    bus.in_rd  = 3'd3;
    bus.in_imm = 8'h5A;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge ck);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    refRegs[2] = exp;
    checks += 2;
    if (lat != ALU_LAT + 1) begin errors++; $display("[TB] FAIL b2b_alu_latency got=%0d exp=%0d", lat, ALU_LAT + 1); end
    if (bus.wb_data !== 8'(exp)) begin errors++; $display("[TB] FAIL b2b_alu_wb got=%h exp=%h", bus.wb_data, 8'(exp)); end
    @(posedge ck);
    #1;
    bus.in_valid = 1'b0;
    refRegs[3] = 8'h5A;
    checks += 2;
    if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ldi_done got=%b exp=1", bus.done); end
    if (bus.wb_data !== 8'h5A) begin errors++; $display("[TB] FAIL b2b_ldi_wb got=%h exp=5a", bus.wb_data); end
    for (int i = 2; i <= 3; i++) begin
      readDbg(i, v);
      checks++;
      if (v !== 8'(refRegs[i])) begin errors++; $display("[TB] FAIL b2b_reg%0d got=%h exp=%h", i, v, 8'(refRegs[i])); end
    end
  endtask

  task automatic test_reset_during_exec();
    logic [7:0] v;
    logic sawDone;
    waitReady();
    bus.in_valid = 1'b1;
    bus.in_ldi   = 1'b0;
    bus.in_ctr   = CTR_OR;
    bus.in_rd    = 3'd0;
    bus.in_rs1   = 3'd6;
    bus.in_rs2   = 3'd7;
    @(posedge ck);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge ck);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) refRegs[i] = 0;
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_exec_ready got=%b exp=1", bus.in_ready); end
    if (bus.alu_a !== 8'h00) begin errors++; $display("[TB] FAIL rst_exec_alu_a got=%h exp=00", bus.alu_a); end
    sawDone = (bus.done === 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge ck);
      #1;
      if (bus.done !== 1'b0) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin errors++; $display("[TB] FAIL rst_exec_done got=1 exp=0"); end
    readDbg(0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("[TB] FAIL rst_exec_r0 got=%h exp=00", v); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, v;
    logic [3:0] c;
    logic d;
    int lat, busy, exp, rd, rs1, rs2, imm, ctr;
    int codes [5] = '{0, 1, 8, 9, 10};
    applyReset();
    for (int n = 0; n < 60; n++) begin
      rd = $urandom_range(0, 7);
      if (n < 8 || $urandom_range(0, 2) == 0) begin
        imm = $urandom_range(0, 255);
        doLdi(rd, imm, d);
        refRegs[rd] = imm;
        checks += 2;
        if (d !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_ldi_done got=%b exp=1", n, d); end
        if (bus.wb_data !== 8'(imm)) begin errors++; $display("[TB] FAIL rnd%0d_ldi_wb got=%h exp=%h", n, bus.wb_data, 8'(imm)); end
      end else begin
        ctr = codes[$urandom_range(0, 4)];
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        exp = refResult(ctr, refRegs[rs1], refRegs[rs2]);
        doAlu(4'(ctr), rd, rs1, rs2, a, b, c, lat, busy);
        checks += 5;
        if (a !== 8'(refRegs[rs1])) begin errors++; $display("[TB] FAIL rnd%0d_alu_a got=%h exp=%h", n, a, 8'(refRegs[rs1])); end
        if (b !== 8'(refRegs[rs2])) begin errors++; $display("[TB] FAIL rnd%0d_alu_b got=%h exp=%h", n, b, 8'(refRegs[rs2])); end
        if (c !== 4'(ctr)) begin errors++; $display("[TB] FAIL rnd%0d_alu_ctr got=%h exp=%h", n, c, 4'(ctr)); end
        if (lat != ALU_LAT + 1) begin errors++; $display("[TB] FAIL rnd%0d_latency got=%0d exp=%0d", n, lat, ALU_LAT + 1); end
        if (bus.wb_data !== 8'(exp)) begin errors++; $display("[TB] FAIL rnd%0d_wb got=%h exp=%h", n, bus.wb_data, 8'(exp)); end
        refRegs[rd] = exp;
      end
`ifdef ALU_SEQ_FLAGS_EN
      checks += 2;
      if (bus.zero_flag !== (refRegs[rd] == 0)) begin errors++; $display("[TB] FAIL rnd%0d_zero_flag got=%b", n, bus.zero_flag); end
      if (bus.neg_flag !== (refRegs[rd] >= 128)) begin errors++; $display("[TB] FAIL rnd%0d_neg_flag got=%b", n, bus.neg_flag); end
`endif
      readDbg(rd, v);
      checks++;
      if (v !== 8'(refRegs[rd])) begin errors++; $display("[TB] FAIL rnd%0d_reg%0d got=%h exp=%h", n, rd, v, 8'(refRegs[rd])); end
    end
    for (int i = 0; i < 8; i++) begin
      readDbg(i, v);
      checks++;
      if (v !== 8'(refRegs[i])) begin errors++; $display("[TB] FAIL rnd_final_reg%0d got=%h exp=%h", i, v, 8'(refRegs[i])); end
    end
  endtask

  initial begin
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_ldi   = 1'b0;
    bus.in_ctr   = 4'h0;
    bus.in_rd    = 3'd0;
    bus.in_rs1   = 3'd0;
    bus.in_rs2   = 3'd0;
    bus.in_imm   = 8'h00;
    bus.dbg_sel  = 3'd0;
    test_reset();
    test_ldi_back_to_back();
    test_alu_add();
    test_sub_wrap();
    test_logic_ops();
    test_back_to_back();
    test_reset_during_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
